cc_branch_resolver: RTL and testbench

- Reader side of the LC-3b condition-code path. Accepts BR requests from decode and tracks in-flight CC-writing instructions with a pending counter.
- Resolves taken/not-taken once the CC register holds the final value for all older writers.
- Returns the branch outcome and target to fetch over a valid/ready handshake.
- Sits between decode/issue, the CC register and the PC-select logic.

---
 rtl/cc_branch_resolver.sv | 123 ++++++++++++
 tb/tb_cc_branch_resolver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cc_branch_resolver.sv
// LC-3b branch resolver: waits until every older CC writer has loaded the CC register,
// then evaluates the BR condition and hands the outcome and target to fetch.
module cc_branch_resolver #(
    parameter int CC_W   = 3,
    parameter int PEND_W = 3,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cc_alloc,
    input  logic              cc_load,
    input  logic [CC_W-1:0]   cc_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [CC_W-1:0]   br_nzp,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [8:0]        br_offset,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_target,
    output logic              pend_full,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, WAIT_CC, RESP} state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state;
    logic [PEND_W-1:0] pend_cnt;
    logic [CC_W-1:0]   nzp_q;
    logic [ADDR_W-1:0] tgt_q;

    logic              accept;
    logic              alloc_ok;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] br_sum;
    logic              resolve_now;
    logic              taken_now;

    assign br_ready  = (state == IDLE) && !rst;
    assign accept    = br_valid && br_ready;
    assign pend_full = (pend_cnt == PEND_MAX);

    // New CC writers may only issue while no branch is in flight or entering.
    assign alloc_ok  = cc_alloc && (state == IDLE) && !accept && !pend_full;

    assign off_ext   = {{(ADDR_W-9){br_offset[8]}}, br_offset};
    assign br_sum    = br_pc + {off_ext[ADDR_W-2:0], 1'b0};

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        resolve_now = 1'b0;
        taken_now   = 1'b0;
        if (state == WAIT_CC) begin
            if (nzp_q == '0) begin
                resolve_now = 1'b1;
            end else if (nzp_q == '1) begin
                resolve_now = 1'b1;
                taken_now   = 1'b1;
            end else if (pend_cnt == '0) begin
                // Registered count is zero, so cc_in already holds the final flags.
                resolve_now = 1'b1;
                taken_now   = |(nzp_q & cc_in);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_cnt   <= '0;
            nzp_q      <= '0;
            tgt_q      <= '0;
            res_valid  <= 1'b0;
            res_taken  <= 1'b0;
            res_target <= '0;
            err        <= 1'b0;
        end else begin
            if (cc_alloc && !alloc_ok) begin
                err <= 1'b1;
            end

            if (alloc_ok && !cc_load) begin
                pend_cnt <= pend_cnt + PEND_W'(1);
            end else if (!alloc_ok && cc_load) begin
                if (pend_cnt == '0) begin
                    err <= 1'b1;
                end else begin
                    pend_cnt <= pend_cnt - PEND_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        nzp_q <= br_nzp;
                        tgt_q <= br_sum;
                        state <= WAIT_CC;
                    end
                end
                WAIT_CC: begin
                    if (resolve_now) begin
                        res_taken  <= taken_now;
                        res_target <= tgt_q;
                        res_valid  <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_branch_resolver.sv
// Directed bench for cc_branch_resolver: latency, CC wait, target wrap, backpressure,
// pending-counter boundaries and synchronous reset mid-operation.
module tb_cc_branch_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cc_alloc;
    logic        cc_load;
    logic [2:0]  cc_in;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_nzp;
    logic [15:0] br_pc;
    logic [8:0]  br_offset;
    logic        res_valid;
    logic        res_ready;
    logic        res_taken;
    logic [15:0] res_target;
    logic        pend_full;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_branch_resolver #(.CC_W(3), .PEND_W(3), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cc_alloc   (cc_alloc),
        .cc_load    (cc_load),
        .cc_in      (cc_in),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_nzp     (br_nzp),
        .br_pc      (br_pc),
        .br_offset  (br_offset),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_taken  (res_taken),
        .res_target (res_target),
        .pend_full  (pend_full),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just past it; inputs change only here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_br_ready", br_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_err", err, 0);
        check("rst_pend_full", pend_full, 0);
        rst = 1'b0;
        #1;
        check("post_rst_br_ready", br_ready, 1);
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            cc_alloc = 1'b1;
            tick();
        end
        cc_alloc = 1'b0;
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) begin
            cc_load = 1'b1;
            tick();
        end
        cc_load = 1'b0;
    endtask

    // Presents one branch for a single cycle; returns one cycle after the accept edge.
    task automatic send_branch(input logic [2:0] nzp, input logic [15:0] pc, input logic [8:0] off);
        check("send_br_ready", br_ready, 1);
        br_valid  = 1'b1;
        br_nzp    = nzp;
        br_pc     = pc;
        br_offset = off;
        tick();
        br_valid  = 1'b0;
        check("wait_br_ready", br_ready, 0);
        check("wait_res_valid", res_valid, 0);
    endtask

    task automatic expect_result(input string tag, input logic taken, input logic [15:0] tgt);
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_taken"}, res_taken, taken);
        check({tag, "_target"}, res_target, tgt);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("consume_res_valid", res_valid, 0);
        check("consume_br_ready", br_ready, 1);
    endtask

    initial begin
        rst = 1'b1; cc_alloc = 1'b0; cc_load = 1'b0; cc_in = 3'b010;
        br_valid = 1'b0; br_nzp = 3'b000; br_pc = 16'h0; br_offset = 9'h0; res_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        check("reset_res_taken", res_taken, 0);
        check("reset_res_target", res_target, 16'h0000);
        do_reset();

        // BRz, nothing pending: result at T+2
        cc_in = 3'b010;
        send_branch(3'b010, 16'h3002, 9'h005);
        tick();
        expect_result("brz", 1'b1, 16'h300C);
        consume();

        // BRn behind two pending writers
        alloc_n(2);
        cc_in = 3'b010;
        send_branch(3'b100, 16'h1000, 9'h010);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("brn_held", res_valid, 0);
        end
        cc_in = 3'b100;
        load_n(1);
        check("brn_after_load1", res_valid, 0);
        load_n(1);
        check("brn_after_load2", res_valid, 0);
        tick();
        expect_result("brn", 1'b1, 16'h1020);
        check("brn_err", err, 0);
        consume();

        // Negative offset wraps below zero; condition false
        cc_in = 3'b001;
        send_branch(3'b100, 16'h0000, 9'h1FF);
        tick();
        expect_result("wrap", 1'b0, 16'hFFFE);
        consume();

        // BRnzp with three pending writers resolves without waiting
        alloc_n(3);
        send_branch(3'b111, 16'h2000, 9'h0FF);
        tick();
        expect_result("nzp", 1'b1, 16'h21FE);
        consume();

        // nzp=000 never taken, then backpressure for 5 cycles
        send_branch(3'b000, 16'h4000, 9'h100);
        tick();
        expect_result("never", 1'b0, 16'h3E00);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_result("hold", 1'b0, 16'h3E00);
            check("hold_br_ready", br_ready, 0);
        end
        consume();
        check("no_err_yet", err, 0);

        // Alloc and load together at 3 keep 3: three more allocs give 6, fourth gives 7
        cc_alloc = 1'b1; cc_load = 1'b1;
        tick();
        cc_alloc = 1'b0; cc_load = 1'b0;
        alloc_n(3);
        check("cnt6_full", pend_full, 0);
        alloc_n(1);
        check("cnt7_full", pend_full, 1);
        check("cnt7_err", err, 0);
        alloc_n(1);
        check("overflow_full", pend_full, 1);
        check("overflow_err", err, 1);
        do_reset();

        // Load with nothing pending
        load_n(1);
        check("underflow_err", err, 1);
        check("underflow_full", pend_full, 0);
        do_reset();

        // Alloc while a branch waits is ignored: two loads still release it
        alloc_n(2);
        cc_in = 3'b010;
        send_branch(3'b010, 16'h5000, 9'h002);
        alloc_n(1);
        check("late_alloc_err", err, 1);
        load_n(2);
        tick();
        expect_result("late_alloc", 1'b1, 16'h5004);

        // Reset while in RESP
        rst = 1'b1;
        tick();
        check("rst_resp_valid", res_valid, 0);
        check("rst_resp_err", err, 0);
        check("rst_resp_full", pend_full, 0);
        rst = 1'b0;
        #1;
        check("rst_resp_idle", br_ready, 1);

        // Reset while in WAIT_CC with a writer pending
        alloc_n(1);
        send_branch(3'b010, 16'h6000, 9'h001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_wait_idle", br_ready, 1);
        check("rst_wait_valid", res_valid, 0);
        check("rst_wait_err", err, 0);
        // Pending count is back to zero, so a fresh branch resolves at T+2
        cc_in = 3'b010;
        send_branch(3'b010, 16'h6000, 9'h001);
        tick();
        expect_result("post_rst", 1'b1, 16'h6002);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
